mmc_spi_master: RTL and testbench

- SPI initiator (mode 0, MSB first) that drives the MMC/SD bus (mmc_sck/mmc_mosi/mmc_cs/mmc_miso) toward either the physical SD card or the virtual VHD SD-card responder.
- Executes byte-level commands issued by the disk-interface logic: single transfer, poll-until-response, CS-high idle clocking, and CS-only updates.
- Has selectable slow (init) and fast SCK rates derived from clk_sys.

---
 rtl/mmc_spi_pkg.sv | 35 +++
 rtl/mmc_spi_shifter.sv | 80 ++++++++
 rtl/mmc_spi_master.sv | 167 ++++++++++++++++
 tb/tb_mmc_spi_master.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmc_spi_pkg.sv
// Shared types and constants for the MMC/SD SPI initiator.
package mmc_spi_pkg;

    localparam int unsigned HALF_SLOW_DEF = 32;
    localparam int unsigned HALF_FAST_DEF = 1;
    localparam int unsigned POLL_MAX_DEF  = 1024;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned BIT_W         = 3;
    localparam int unsigned BYTE_W        = 11;

    localparam logic [DATA_W-1:0] IDLE_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        CMD_XFER     = 2'd0,
        CMD_POLL     = 2'd1,
        CMD_IDLE_CLK = 2'd2,
        CMD_CS_ONLY  = 2'd3
    } cmd_t;

    // SETUP and NEXT coincide with the shifter load edge, so the register
    // only ever holds IDLE, LOW, HIGH or FINISH.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_NEXT,
        ST_FINISH
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mmc_spi_shifter.sv
// Half-period divider plus 8-bit mode-0 shift/sample engine.
// A load presents bit7 immediately; a load on the final falling edge chains bytes back-to-back.
module mmc_spi_shifter
    import mmc_spi_pkg::*;
#(
    parameter int unsigned HALF_W = 6
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [HALF_W-1:0] i_half,
    input  logic              i_miso,
    output logic              o_sck,
    output logic              o_mosi,
    output logic [DATA_W-1:0] o_rx,
    output logic              o_rise_c,
    output logic              o_fall_c,
    output logic              o_last_c
);

    logic              r_sck;
    logic              r_mosi;
    logic              r_active;
    logic [DATA_W-1:0] r_sh;
    logic [DATA_W-1:0] r_rx;
    logic [HALF_W-1:0] r_cnt;
    logic [HALF_W-1:0] r_half;
    logic [BIT_W-1:0]  r_bit;
    logic              w_end;

    assign w_end    = r_active && (r_cnt == HALF_W'(r_half - HALF_W'(1)));
    assign o_rise_c = w_end && !r_sck;
    assign o_fall_c = w_end && r_sck;
    assign o_last_c = o_fall_c && (r_bit == BIT_W'(7));

    assign o_sck  = r_sck;
    assign o_mosi = r_mosi;
    assign o_rx   = r_rx;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sck    <= 1'b0;
            r_mosi   <= 1'b1;
            r_active <= 1'b0;
            r_sh     <= '1;
            r_rx     <= '0;
            r_cnt    <= '0;
            r_half   <= '0;
            r_bit    <= '0;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_sck    <= 1'b0;
            r_mosi   <= i_data[DATA_W-1];
            r_sh     <= {i_data[DATA_W-2:0], 1'b1};
            r_cnt    <= '0;
            r_bit    <= '0;
            r_half   <= i_half;
        end else if (w_end) begin
            r_cnt <= '0;
            if (!r_sck) begin
                r_sck <= 1'b1;
                r_rx  <= {r_rx[DATA_W-2:0], i_miso};
            end else begin
                r_sck <= 1'b0;
                if (r_bit == BIT_W'(7)) begin
                    r_active <= 1'b0;
                    r_mosi   <= 1'b1;
                end else begin
                    r_bit  <= BIT_W'(r_bit + BIT_W'(1));
                    r_mosi <= r_sh[DATA_W-1];
                    r_sh   <= {r_sh[DATA_W-2:0], 1'b1};
                end
            end
        end else if (r_active) begin
            r_cnt <= HALF_W'(r_cnt + HALF_W'(1));
        end
    end

endmodule

// File: rtl/mmc_spi_master.sv
// SPI initiator for the MMC/SD bus: command sequencing, chip select, byte counting
// and POLL timeout around the mmc_spi_shifter bit engine.
module mmc_spi_master
    import mmc_spi_pkg::*;
#(
    parameter int unsigned HALF_SLOW = HALF_SLOW_DEF,
    parameter int unsigned HALF_FAST = HALF_FAST_DEF,
    parameter int unsigned POLL_MAX  = POLL_MAX_DEF
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_data,
    input  logic       cs_en,
    input  logic       fast,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       timeout,
    output logic       mmc_sck,
    output logic       mmc_mosi,
    output logic       mmc_cs,
    input  logic       mmc_miso
);

    localparam int unsigned HALF_W = $clog2(max_u(HALF_SLOW, HALF_FAST) + 1);

    state_t              r_state;
    state_t              w_next;
    cmd_t                r_cmd;
    cmd_t                w_cmd;
    logic                r_cs;
    logic                r_busy;
    logic                r_done;
    logic                r_timeout;
    logic [DATA_W-1:0]   r_rx_data;
    logic [BYTE_W-1:0]   r_bytes;
    logic [BYTE_W-1:0]   r_target;
    logic [HALF_W-1:0]   r_half;

    logic                w_accept;
    logic                w_load;
    logic                w_more;
    logic                w_byte_end;
    logic [DATA_W-1:0]   w_tx;
    logic [DATA_W-1:0]   w_rx;
    logic [HALF_W-1:0]   w_half;
    logic [BYTE_W-1:0]   w_bytes_inc;
    logic                w_rise;
    logic                w_fall;
    logic                w_last;

    assign w_cmd = cmd_t'(cmd);

    mmc_spi_shifter #(
        .HALF_W (HALF_W)
    ) u_shifter (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .i_load   (w_load),
        .i_data   (w_tx),
        .i_half   (w_half),
        .i_miso   (mmc_miso),
        .o_sck    (mmc_sck),
        .o_mosi   (mmc_mosi),
        .o_rx     (w_rx),
        .o_rise_c (w_rise),
        .o_fall_c (w_fall),
        .o_last_c (w_last)
    );

    // Next state; the done cycle (FINISH) is idle and may accept a new start.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_more      = 1'b0;
        w_byte_end  = 1'b0;
        w_tx        = IDLE_BYTE;
        w_half      = r_half;
        w_bytes_inc = BYTE_W'(r_bytes + BYTE_W'(1));
        case (r_state)
            ST_IDLE, ST_FINISH: begin
                w_next = ST_IDLE;
                if (start) begin
                    w_accept = 1'b1;
                    w_half   = fast ? HALF_W'(HALF_FAST) : HALF_W'(HALF_SLOW);
                    if (w_cmd == CMD_CS_ONLY) begin
                        w_next = ST_FINISH;
                    end else begin
                        w_next = ST_LOW;
                        w_load = 1'b1;
                        if (w_cmd == CMD_XFER) w_tx = tx_data;
                    end
                end
            end
            ST_LOW: begin
                if (w_rise) w_next = ST_HIGH;
            end
            ST_HIGH: begin
                if (w_last) begin
                    w_byte_end = 1'b1;
                    case (r_cmd)
                        CMD_POLL:     w_more = (w_rx == IDLE_BYTE) &&
                                               (w_bytes_inc != BYTE_W'(POLL_MAX));
                        CMD_IDLE_CLK: w_more = (w_bytes_inc != r_target);
                        default:      w_more = 1'b0;
                    endcase
                    if (w_more) begin
                        w_load = 1'b1;
                        w_next = ST_LOW;
                    end else begin
                        w_next = ST_FINISH;
                    end
                end else if (w_fall) begin
                    w_next = ST_LOW;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cmd     <= CMD_XFER;
            r_cs      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_rx_data <= '0;
            r_bytes   <= '0;
            r_target  <= '0;
            r_half    <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_cmd     <= w_cmd;
                r_timeout <= 1'b0;
                r_bytes   <= '0;
                r_half    <= w_half;
                r_target  <= (tx_data == 8'd0) ? BYTE_W'(256) : BYTE_W'(tx_data);
                r_cs      <= (w_cmd == CMD_IDLE_CLK) ? 1'b1 : ~cs_en;
                r_busy    <= (w_cmd != CMD_CS_ONLY);
                r_done    <= (w_cmd == CMD_CS_ONLY);
            end
            if (w_byte_end) begin
                r_bytes <= w_bytes_inc;
                if (!w_more) begin
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_rx_data <= w_rx;
                    r_timeout <= (r_cmd == CMD_POLL) && (w_rx == IDLE_BYTE);
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign timeout = r_timeout;
    assign mmc_cs  = r_cs;

endmodule

// File: tb/tb_mmc_spi_master.sv
// Self-checking bench: per-cycle waveform model derived from bit/byte arithmetic plus literal checks.
module tb_mmc_spi_master;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic [1:0] cmd     = 2'd0;
    logic [7:0] tx_data = 8'd0;
    logic       cs_en   = 1'b0;
    logic       fast    = 1'b0;
    logic       mmc_miso = 1'b1;
    logic       busy, done, timeout, mmc_sck, mmc_mosi, mmc_cs;
    logic [7:0] rx_data;

    mmc_spi_master dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .start    (start),
        .cmd      (cmd),
        .tx_data  (tx_data),
        .cs_en    (cs_en),
        .fast     (fast),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .timeout  (timeout),
        .mmc_sck  (mmc_sck),
        .mmc_mosi (mmc_mosi),
        .mmc_cs   (mmc_cs),
        .mmc_miso (mmc_miso)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model of the command in flight
    bit         m_active = 1'b0;
    int         m_T, m_h, m_n;
    logic [1:0] m_cmd;
    logic [7:0] m_txb;
    logic       m_cs = 1'b1;
    logic       m_cs_new;
    logic [7:0] m_rx = 8'h00;
    logic       m_to = 1'b0;
    logic [7:0] m_resp [0:1023];

    logic       e_sck = 1'b0, e_mosi = 1'b1, e_cs = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_to = 1'b0;
    logic [7:0] e_rx = 8'h00;
    bit         chk_en = 1'b0;

    int         rise_cnt = 0;
    int         done_cnt = 0;
    logic       prev_sck = 1'b0;
    logic [7:0] mosi_cap = 8'h00;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (chk_en) begin
            cmp("sck",     32'(mmc_sck),  32'(e_sck));
            cmp("mosi",    32'(mmc_mosi), 32'(e_mosi));
            cmp("cs",      32'(mmc_cs),   32'(e_cs));
            cmp("busy",    32'(busy),     32'(e_busy));
            cmp("done",    32'(done),     32'(e_done));
            cmp("rx_data", 32'(rx_data),  32'(e_rx));
            cmp("timeout", 32'(timeout),  32'(e_to));
        end
        if (mmc_sck === 1'b1 && prev_sck === 1'b0) begin
            rise_cnt++;
            mosi_cap = {mosi_cap[6:0], mmc_mosi};
        end
        prev_sck = mmc_sck;
        if (done === 1'b1) done_cnt++;
    end

    // One clock: scramble don't-care inputs, advance the model, drive MISO.
    task automatic tick();
        logic pr;
        int k, tot, by, r, bi;
        pr = reset;
        @(posedge clk_sys);
        #1;
        cyc++;
        start    = 1'b0;
        cmd      = 2'($urandom);
        tx_data  = 8'($urandom);
        cs_en    = 1'($urandom);
        fast     = 1'($urandom);
        mmc_miso = 1'($urandom);
        e_sck = 1'b0; e_mosi = 1'b1; e_busy = 1'b0; e_done = 1'b0;
        if (pr) begin
            m_active = 1'b0; m_cs = 1'b1; m_rx = 8'h00; m_to = 1'b0;
        end else if (m_active) begin
            k = cyc - m_T - 1;
            if (k == 0) begin
                m_to = 1'b0;
                m_cs = m_cs_new;
            end
            if (m_cmd == 2'd3) begin
                e_done = 1'b1;
                m_active = 1'b0;
            end else begin
                tot = 16 * m_h * m_n;
                if (k < tot) begin
                    by = k / (16 * m_h);
                    r  = k % (16 * m_h);
                    bi = r / (2 * m_h);
                    e_busy   = 1'b1;
                    e_sck    = ((r % (2 * m_h)) >= m_h);
                    e_mosi   = m_txb[7 - bi];
                    mmc_miso = m_resp[by][7 - bi];
                end else begin
                    e_done   = 1'b1;
                    m_rx     = m_resp[m_n - 1];
                    m_to     = (m_cmd == 2'd1) && (m_resp[m_n - 1] == 8'hFF);
                    m_active = 1'b0;
                end
            end
        end
        e_cs = m_cs; e_rx = m_rx; e_to = m_to;
    endtask

    task automatic do_start(input logic [1:0] c, input logic [7:0] tx, input logic ce, input logic f);
        start = 1'b1; cmd = c; tx_data = tx; cs_en = ce; fast = f;
        if (!m_active && !reset) begin
            m_active = 1'b1;
            m_T      = cyc;
            m_cmd    = c;
            m_h      = f ? 1 : 32;
            m_txb    = (c == 2'd0) ? tx : 8'hFF;
            m_cs_new = (c == 2'd2) ? 1'b1 : ~ce;
            case (c)
                2'd0: m_n = 1;
                2'd1: begin
                    m_n = 1024;
                    for (int i = 1023; i >= 0; i--) if (m_resp[i] != 8'hFF) m_n = i + 1;
                end
                2'd2: m_n = (tx == 8'd0) ? 256 : int'(tx);
                default: m_n = 0;
            endcase
        end
    endtask

    task automatic wait_done(input int bound, input bit inject, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done === 1'b1) begin
                dcyc = cyc;
                break;
            end
            if (inject && m_active && ($urandom_range(0, 7) == 0)) start = 1'b1;
        end
        if (dcyc < 0) begin
            checks++;
            errors++;
            $display("FAIL done_wait cyc=%0d actual=no_done required=done within %0d", cyc, bound);
        end
    endtask

    task automatic fill_resp(input logic [7:0] v);
        for (int i = 0; i < 1024; i++) m_resp[i] = v;
    endtask

    initial begin
        int T, d, r0, d0, c, nff;
        logic [7:0] v;

        tick();
        chk_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        cmp("rst_sck",  32'(mmc_sck),  32'd0);
        cmp("rst_mosi", 32'(mmc_mosi), 32'd1);
        cmp("rst_cs",   32'(mmc_cs),   32'd1);
        cmp("rst_busy", 32'(busy),     32'd0);
        cmp("rst_done", 32'(done),     32'd0);
        cmp("rst_rx",   32'(rx_data),  32'h00);
        cmp("rst_to",   32'(timeout),  32'd0);

        // XFER fast, plus an ignored CS_ONLY start while busy
        fill_resp(8'hFF);
        m_resp[0] = 8'hA5;
        T = cyc;
        do_start(2'd0, 8'h40, 1'b1, 1'b1);
        repeat (4) tick();
        do_start(2'd3, 8'h00, 1'b0, 1'b1);
        wait_done(100, 1'b1, d);
        cmp("xfer_latency", 32'(d - T), 32'd17);
        cmp("xfer_rx",      32'(rx_data),  32'hA5);
        cmp("xfer_mosi",    32'(mosi_cap), 32'h40);
        cmp("xfer_cs",      32'(mmc_cs),   32'd0);
        cmp("xfer_sck",     32'(mmc_sck),  32'd0);

        // CS_ONLY issued in the done cycle
        r0 = rise_cnt;
        T = cyc;
        do_start(2'd3, 8'h00, 1'b0, 1'b1);
        wait_done(10, 1'b0, d);
        cmp("csonly_latency", 32'(d - T), 32'd1);
        cmp("csonly_cs",      32'(mmc_cs), 32'd1);
        tick();
        tick();
        cmp("csonly_rises",   32'(rise_cnt - r0), 32'd0);

        // IDLE_CLK slow, 10 bytes
        for (int i = 0; i < 1024; i++) m_resp[i] = 8'($urandom);
        r0 = rise_cnt;
        T = cyc;
        do_start(2'd2, 8'd10, 1'b1, 1'b0);
        wait_done(6000, 1'b1, d);
        cmp("idle_latency", 32'(d - T), 32'd5121);
        cmp("idle_rises",   32'(rise_cnt - r0), 32'd80);
        cmp("idle_cs",      32'(mmc_cs), 32'd1);

        // POLL with response on the third byte
        fill_resp(8'hFF);
        m_resp[2] = 8'h01;
        tick();
        T = cyc;
        do_start(2'd1, 8'h00, 1'b1, 1'b1);
        wait_done(200, 1'b1, d);
        cmp("poll_latency", 32'(d - T), 32'd49);
        cmp("poll_rx",      32'(rx_data), 32'h01);
        cmp("poll_to",      32'(timeout), 32'd0);

        // POLL with MISO stuck high
        fill_resp(8'hFF);
        tick();
        T = cyc;
        do_start(2'd1, 8'h00, 1'b1, 1'b1);
        wait_done(17000, 1'b0, d);
        cmp("pollto_latency", 32'(d - T), 32'd16385);
        cmp("pollto_to",      32'(timeout), 32'd1);
        cmp("pollto_rx",      32'(rx_data), 32'hFF);

        // IDLE_CLK count 0 means 256 bytes
        for (int i = 0; i < 1024; i++) m_resp[i] = 8'($urandom);
        r0 = rise_cnt;
        T = cyc;
        do_start(2'd2, 8'd0, 1'b0, 1'b1);
        wait_done(5000, 1'b1, d);
        cmp("idle256_latency", 32'(d - T), 32'd4097);
        cmp("idle256_rises",   32'(rise_cnt - r0), 32'd2048);

        // Randomized command mix
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            c = $urandom_range(0, 3);
            for (int i = 0; i < 1024; i++) m_resp[i] = 8'($urandom);
            if (c == 1) begin
                nff = $urandom_range(0, 4);
                for (int i = 0; i < nff; i++) m_resp[i] = 8'hFF;
                v = 8'($urandom);
                if (v == 8'hFF) v = 8'h00;
                m_resp[nff] = v;
            end
            do_start(2'(c), (c == 2) ? 8'($urandom_range(1, 8)) : 8'($urandom),
                     1'($urandom), (c == 0) ? 1'($urandom) : 1'b1);
            wait_done(2000, 1'b1, d);
        end

        // Reset during bit 4 of a slow XFER
        tick();
        for (int i = 0; i < 1024; i++) m_resp[i] = 8'($urandom);
        do_start(2'd0, 8'h3C, 1'b1, 1'b0);
        repeat (4 * 64 + 5) tick();
        reset = 1'b1;
        d0 = done_cnt;
        tick();
        cmp("abort_sck",  32'(mmc_sck),  32'd0);
        cmp("abort_mosi", 32'(mmc_mosi), 32'd1);
        cmp("abort_cs",   32'(mmc_cs),   32'd1);
        cmp("abort_busy", 32'(busy),     32'd0);
        cmp("abort_done", 32'(done),     32'd0);
        reset = 1'b0;
        repeat (600) tick();
        cmp("abort_no_done", 32'(done_cnt - d0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
